// File: rtl/regfile_dest_decoder.sv
// Write-back destination decoder with a pending-write scoreboard.
// Produces a registered one-hot register-file write enable from the
// write-back address. It also tracks one pending bit per register: the bit
// is set on an accepted issue and cleared on write-back. Combinational
// source-hazard and WAW issue-stall flags feed the issue stage.
module regfile_dest_decoder #(
  parameter int ADDR_W       = 3,
  parameter int R0_HARDWIRED = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_dest,
  output logic                issue_stall,
  input  logic [ADDR_W-1:0]   src_a,
  input  logic [ADDR_W-1:0]   src_b,
  output logic                hazard_a,
  output logic                hazard_b,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_dest,
  output logic [(1<<ADDR_W)-1:0] en,
  output logic [(1<<ADDR_W)-1:0] pending,
  output logic [ADDR_W:0]     pending_cnt,
  output logic                wb_err
);

  localparam int NREGS = 1 << ADDR_W;

  // Population count sized to hold NREGS without wrapping.
  function automatic logic [ADDR_W:0] popcount(input logic [NREGS-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) begin
      c = c + {{ADDR_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  logic [NREGS-1:0] r_en;
  logic [NREGS-1:0] r_pending;
  logic [ADDR_W:0]  r_cnt;
  logic             r_wb_err;

  logic             w_wb_supp;
  logic             w_issue_supp;
  logic             w_src_a_supp;
  logic             w_src_b_supp;
  logic             w_issue_stall;
  logic             w_hazard_a;
  logic             w_hazard_b;
  logic             w_accept;
  logic [NREGS-1:0] w_en_next;
  logic [NREGS-1:0] w_pending_next;
  logic             w_err_next;

  // Identify accesses to a hardwired register 0, which are ignored.
  always_comb begin
    w_wb_supp    = 1'b0;
    w_issue_supp = 1'b0;
    w_src_a_supp = 1'b0;
    w_src_b_supp = 1'b0;
    if (R0_HARDWIRED != 0) begin
      w_wb_supp    = (wb_dest    == '0);
      w_issue_supp = (issue_dest == '0);
      w_src_a_supp = (src_a      == '0);
      w_src_b_supp = (src_b      == '0);
    end else begin
      w_wb_supp    = 1'b0;
      w_issue_supp = 1'b0;
      w_src_a_supp = 1'b0;
      w_src_b_supp = 1'b0;
    end
  end

  // WAW stall and RAW hazard flags; a same-cycle write-back bypasses both.
  always_comb begin
    w_issue_stall = issue_valid & ~w_issue_supp & r_pending[issue_dest]
                    & ~(wb_valid & (wb_dest == issue_dest));
    w_hazard_a    = r_pending[src_a] & ~w_src_a_supp
                    & ~(wb_valid & (wb_dest == src_a));
    w_hazard_b    = r_pending[src_b] & ~w_src_b_supp
                    & ~(wb_valid & (wb_dest == src_b));
    w_accept      = issue_valid & ~w_issue_stall & ~w_issue_supp;
  end

  // Next scoreboard, enable and error state; set wins over clear on one index.
  always_comb begin
    w_en_next      = '0;
    w_pending_next = r_pending;
    w_err_next     = r_wb_err;
    if (wb_valid) begin
      w_pending_next[wb_dest] = 1'b0;
    end else begin
      w_pending_next = r_pending;
    end
    if (wb_valid && !w_wb_supp) begin
      w_en_next  = {{(NREGS-1){1'b0}}, 1'b1} << wb_dest;
      w_err_next = r_wb_err | ~r_pending[wb_dest];
    end else begin
      w_en_next  = '0;
      w_err_next = r_wb_err;
    end
    if (w_accept) begin
      w_pending_next[issue_dest] = 1'b1;
    end else begin
      w_err_next = w_err_next;
    end
  end

  // State registers; reset discards every reservation and the error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en      <= '0;
      r_pending <= '0;
      r_cnt     <= '0;
      r_wb_err  <= 1'b0;
    end else begin
      r_en      <= w_en_next;
      r_pending <= w_pending_next;
      r_cnt     <= popcount(w_pending_next);
      r_wb_err  <= w_err_next;
    end
  end

  assign issue_stall = w_issue_stall;
  assign hazard_a    = w_hazard_a;
  assign hazard_b    = w_hazard_b;
  assign en          = r_en;
  assign pending     = r_pending;
  assign pending_cnt = r_cnt;
  assign wb_err      = r_wb_err;

endmodule
